// File: rtl/video_pkg.sv
// video_pkg: shared timing constants, colour type and colour constants for
// the 800x600@72 Hz raster generator.
//
// Contents:
//   HACTIVE..VBP       default raster timing (pixels / lines)
//   HTOTAL, VTOTAL     derived line and frame lengths
//   HS_START/HS_END    horizontal sync window, start inclusive, end exclusive
//   VS_START/VS_END    vertical sync window, start inclusive, end exclusive
//   CURSOR_HALF        default cursor half-size
//   rgb_t              packed {r,g,b} pixel
//   COLOR_*            cursor, background, crosshair and blank colours
package video_pkg;

  localparam int HACTIVE = 800;
  localparam int HFP     = 56;
  localparam int HSYNC   = 120;
  localparam int HBP     = 64;
  localparam int VACTIVE = 600;
  localparam int VFP     = 37;
  localparam int VSYNC   = 6;
  localparam int VBP     = 23;

  localparam int HTOTAL   = HACTIVE + HFP + HSYNC + HBP;   // 1040
  localparam int VTOTAL   = VACTIVE + VFP + VSYNC + VBP;   // 666
  localparam int HS_START = HACTIVE + HFP;                 // 856
  localparam int HS_END   = HS_START + HSYNC;              // 976
  localparam int VS_START = VACTIVE + VFP;                 // 637
  localparam int VS_END   = VS_START + VSYNC;              // 643

  localparam int CURSOR_HALF = 8;
  localparam int CW          = 11;   // coordinate width

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_FG     = 24'hFFFFFF;
  localparam rgb_t COLOR_BG     = 24'h000080;
  localparam rgb_t COLOR_XHAIR  = 24'h404040;
  localparam rgb_t COLOR_BLACK  = 24'h000000;

endpackage

// File: rtl/video_timing.sv
// video_timing: free-running raster counters with unregistered decode of
// sync, blanking and frame markers. The parent registers everything, so the
// decode here is the value for the pixel currently addressed by (xc,yc).
//
// Ports:
//   clk, reset_n   pixel clock, asynchronous active-low reset
//   xc, yc         current horizontal / vertical position
//   hs, vs         raw sync decode, active high
//   blank          raw blanking decode, 1 outside the active area
//   sof            raw decode of pixel (0,0)
//   eof            raw decode of the first pixel after the last active pixel
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = HACTIVE,
  parameter int H_FP     = HFP,
  parameter int H_SYNC   = HSYNC,
  parameter int H_BP     = HBP,
  parameter int V_ACTIVE = VACTIVE,
  parameter int V_FP     = VFP,
  parameter int V_SYNC   = VSYNC,
  parameter int V_BP     = VBP
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [CW-1:0] xc,
  output logic [CW-1:0] yc,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sof,
  output logic          eof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_ACTIVE + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_ACTIVE + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xc <= '0;
      yc <= '0;
    end else if (xc == CW'(H_TOTAL - 1)) begin
      xc <= '0;
      if (yc == CW'(V_TOTAL - 1)) yc <= '0;
      else                        yc <= yc + 1'b1;
    end else begin
      xc <= xc + 1'b1;
    end
  end

  always_comb begin
    hs    = (xc >= CW'(H_SS)) && (xc < CW'(H_SE));
    vs    = (yc >= CW'(V_SS)) && (yc < CW'(V_SE));
    blank = (xc >= CW'(H_ACTIVE)) || (yc >= CW'(V_ACTIVE));
    sof   = (xc == '0) && (yc == '0);
    eof   = (xc == CW'(H_ACTIVE)) && (yc == CW'(V_ACTIVE - 1));
  end

endmodule

// File: rtl/video_gen.sv
// video_gen: raster generator with a square cursor composited over a flat
// background. All outputs are registered one cycle after the (xc,yc) decode
// and are mutually aligned.
//
// Build option: define VIDEO_CROSSHAIR_EN to draw a full-screen crosshair
// through the latched centre (cursor colour still wins over the crosshair).
//
// Ports:
//   clk, reset_n       pixel clock, asynchronous active-low reset
//   centerX, centerY   signed cursor centre from the controller
//   SOF, EOF           one-cycle frame markers
//   spotX, spotY       current raster position
//   hs, vs             sync, active high
//   blank              1 outside the active area
//   r, g, b            pixel colour, forced to 0 while blanked
module video_gen
  import video_pkg::*;
#(
  parameter int          H_ACTIVE = HACTIVE,
  parameter int          H_FP     = HFP,
  parameter int          H_SYNC   = HSYNC,
  parameter int          H_BP     = HBP,
  parameter int          V_ACTIVE = VACTIVE,
  parameter int          V_FP     = VFP,
  parameter int          V_SYNC   = VSYNC,
  parameter int          V_BP     = VBP,
  parameter int          HALF     = CURSOR_HALF,
  parameter logic [23:0] FG       = COLOR_FG,
  parameter logic [23:0] BG       = COLOR_BG
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [CW-1:0] centerX,
  input  logic signed [CW-1:0] centerY,
  output logic                 SOF,
  output logic                 EOF,
  output logic        [CW-1:0] spotX,
  output logic        [CW-1:0] spotY,
  output logic                 hs,
  output logic                 vs,
  output logic                 blank,
  output logic        [7:0]    r,
  output logic        [7:0]    g,
  output logic        [7:0]    b
);

  localparam logic signed [CW:0] HALF_S = (CW+1)'(HALF);

  logic [CW-1:0] xc, yc;
  logic          hs_raw, vs_raw, blank_raw, sof_raw, eof_raw;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .xc      (xc),
    .yc      (yc),
    .hs      (hs_raw),
    .vs      (vs_raw),
    .blank   (blank_raw),
    .sof     (sof_raw),
    .eof     (eof_raw)
  );

  logic signed [CW-1:0] cx, cy;
  logic signed [CW-1:0] cx_use, cy_use;
  logic signed [CW:0]   dx, dy;
  logic                 hit;
  rgb_t                 pix;
  rgb_t                 pix_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx <= CW'(400);
      cy <= CW'(300);
    end else if (sof_raw) begin
      cx <= centerX;
      cy <= centerY;
    end
  end

  // Pixel (0,0) is decoded in the same cycle the latch loads, so it takes
  // the incoming centre directly; this keeps the whole frame consistent.
  assign cx_use = sof_raw ? centerX : cx;
  assign cy_use = sof_raw ? centerY : cy;

  // Worst-case dx (1039 - (-1024)) wraps to a large negative value, which is
  // never within +/-HALF, so clipping still holds without a wider subtractor.
  assign dx  = $signed({1'b0, xc}) - $signed({cx_use[CW-1], cx_use});
  assign dy  = $signed({1'b0, yc}) - $signed({cy_use[CW-1], cy_use});
  assign hit = (dx >= -HALF_S) && (dx <= HALF_S) &&
               (dy >= -HALF_S) && (dy <= HALF_S);

  always_comb begin
    pix = rgb_t'(BG);
`ifdef VIDEO_CROSSHAIR_EN
    if ((dx == '0) || (dy == '0)) pix = COLOR_XHAIR;
`endif
    if (hit)       pix = rgb_t'(FG);
    if (blank_raw) pix = COLOR_BLACK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SOF   <= 1'b0;
      EOF   <= 1'b0;
      spotX <= '0;
      spotY <= '0;
      hs    <= 1'b0;
      vs    <= 1'b0;
      blank <= 1'b1;
      pix_q <= COLOR_BLACK;
    end else begin
      SOF   <= sof_raw;
      EOF   <= eof_raw;
      spotX <= xc;
      spotY <= yc;
      hs    <= hs_raw;
      vs    <= vs_raw;
      blank <= blank_raw;
      pix_q <= pix;
    end
  end

  assign r = pix_q.r;
  assign g = pix_q.g;
  assign b = pix_q.b;

endmodule

// File: tb/tb_video_gen.sv
// Directed bench. "dut" runs a shrunken raster (56x38 total, 40x30 active,
// cursor half-size 3) so several whole frames fit in a short run; "dut_d"
// runs the full 800x600 timing and is checked on its first line only.
module tb_video_gen;

  localparam int HT = 56;          // 40 + 4 + 6 + 6
  localparam int VT = 38;          // 30 + 3 + 2 + 3
  localparam int FR = HT * VT;     // 2128 cycles per frame
  localparam int EOF_OFS = 29 * HT + 40;   // 1664
  localparam logic [23:0] C_FG = 24'hFFFFFF;
  localparam logic [23:0] C_BG = 24'h000080;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [10:0] center_x = 11'sd20;
  logic signed [10:0] center_y = 11'sd15;
  logic signed [10:0] d_cx = 11'sd400;
  logic signed [10:0] d_cy = 11'sd300;

  logic sof, eof, hs, vs, blank;
  logic [10:0] spot_x, spot_y;
  logic [7:0] r, g, b;
  logic d_sof, d_eof, d_hs, d_vs, d_blank;
  logic [10:0] d_spot_x, d_spot_y;
  logic [7:0] d_r, d_g, d_b;

  always #5 clk = ~clk;

  video_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(3), .HALF(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .centerX(center_x), .centerY(center_y),
    .SOF(sof), .EOF(eof), .spotX(spot_x), .spotY(spot_y),
    .hs(hs), .vs(vs), .blank(blank), .r(r), .g(g), .b(b)
  );

  video_gen dut_d (
    .clk(clk), .reset_n(reset_n), .centerX(d_cx), .centerY(d_cy),
    .SOF(d_sof), .EOF(d_eof), .spotX(d_spot_x), .spotY(d_spot_y),
    .hs(d_hs), .vs(d_vs), .blank(d_blank), .r(d_r), .g(d_g), .b(d_b)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, base = 0, p = 0;
  int sof_cnt, eof_cnt, last_sof, last_eof, both_cnt;
  int blank_rgb_bad, hs_bad, vs_bad, fg_cnt;
  int d_hs_cnt, d_hs_first, d_hs_last, d_blank_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int tp(input int x, input int y);
    return y * HT + x;
  endfunction

  task automatic clear_stats();
    sof_cnt = 0; eof_cnt = 0; last_sof = -1; last_eof = -1; both_cnt = 0;
    blank_rgb_bad = 0; hs_bad = 0; vs_bad = 0; fg_cnt = 0;
    d_hs_cnt = 0; d_hs_first = -1; d_hs_last = -1; d_blank_first = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sof) begin sof_cnt++; last_sof = cyc; end
    if (eof) begin eof_cnt++; last_eof = cyc; end
    if (sof && eof) both_cnt++;
    if (blank && ({r, g, b} != 24'h0)) blank_rgb_bad++;
    if (hs !== (spot_x >= 11'd44 && spot_x <= 11'd49)) hs_bad++;
    if (vs !== (spot_y >= 11'd33 && spot_y <= 11'd34)) vs_bad++;
    if ({r, g, b} == C_FG) fg_cnt++;
    if (d_spot_y == 11'd0) begin
      if (d_hs) begin
        d_hs_cnt++;
        if (d_hs_first < 0) d_hs_first = int'(d_spot_x);
        d_hs_last = int'(d_spot_x);
      end
      if (d_blank && d_blank_first < 0) d_blank_first = int'(d_spot_x);
    end
  endtask

  initial begin
    clear_stats();
    // reset state
    repeat (3) tick();
    chk("rst_sof", sof, 1'b0);
    chk("rst_eof", eof, 1'b0);
    chk("rst_hs", hs, 1'b0);
    chk("rst_vs", vs, 1'b0);
    chk("rst_blank", blank, 1'b1);
    chk("rst_spotx", spot_x, 11'd0);
    chk("rst_rgb", {r, g, b}, 24'h0);
    chk("rst_d_blank", d_blank, 1'b1);

    // release: first SOF on the next edge
    reset_n = 1'b1;
    tick();
    clear_stats();
    base = cyc;
    chk("f1_sof", sof, 1'b1);
    chk("f1_spotx", spot_x, 11'd0);
    chk("f1_spoty", spot_y, 11'd0);
    chk("f1_blank0", blank, 1'b0);
    chk("f1_rgb00", {r, g, b}, C_BG);
    chk("d_sof", d_sof, 1'b1);

    // frame 1: centre (20,15); centre moves to X=30 at line 10, must not show yet
    while (cyc - base < FR) begin
      tick();
      p = cyc - base;
      if (p == tp(0, 10)) center_x = 11'sd30;
      if (p == 5)          chk("d_bg", {d_r, d_g, d_b}, C_BG);
      if (p == tp(17, 12)) chk("f1_fg_ul", {r, g, b}, C_FG);
      if (p == tp(23, 18)) chk("f1_fg_lr", {r, g, b}, C_FG);
      if (p == tp(16, 15)) chk("f1_bg_left", {r, g, b}, C_BG);
      if (p == tp(24, 15)) chk("f1_bg_right", {r, g, b}, C_BG);
      if (p == tp(27, 15)) chk("f1_no_tear", {r, g, b}, C_BG);
      if (p == 1039) chk("d_x_last", d_spot_x, 11'd1039);
      if (p == 1040) begin
        chk("d_x_wrap", d_spot_x, 11'd0);
        chk("d_y_inc", d_spot_y, 11'd1);
      end
      if (p == FR - 1) begin
        chk("f1_x_end", spot_x, 11'd55);
        chk("f1_y_end", spot_y, 11'd37);
      end
    end
    chk("f2_sof", sof, 1'b1);
    chk("f2_x_wrap", spot_x, 11'd0);
    chk("f2_y_wrap", spot_y, 11'd0);
    chk("sof_period", last_sof - base, FR);
    chk("eof_ofs", last_eof - base, EOF_OFS);
    chk("eof_count", eof_cnt, 1);
    chk("sof_eof_overlap", both_cnt, 0);
    chk("hs_window", hs_bad, 0);
    chk("vs_window", vs_bad, 0);
    chk("blank_black", blank_rgb_bad, 0);
    chk("d_hs_cnt", d_hs_cnt, 120);
    chk("d_hs_first", d_hs_first, 856);
    chk("d_hs_last", d_hs_last, 975);
    chk("d_blank_first", d_blank_first, 800);

    // frame 2: centre (30,15); switch to (-2,2) at line 20 for the next frame
    base = cyc;
    fg_cnt = 0;
    eof_cnt = 0;
    while (cyc - base < FR - 1) begin
      tick();
      p = cyc - base;
      if (p == tp(0, 20)) begin
        center_x = -11'sd2;
        center_y = 11'sd2;
      end
      if (p == tp(27, 15)) chk("f2_fg_l", {r, g, b}, C_FG);
      if (p == tp(26, 15)) chk("f2_bg_l", {r, g, b}, C_BG);
      if (p == tp(33, 15)) chk("f2_fg_r", {r, g, b}, C_FG);
      if (p == tp(34, 15)) chk("f2_bg_r", {r, g, b}, C_BG);
    end
    chk("f2_fg_count", fg_cnt, 49);
    chk("f2_eof_count", eof_cnt, 1);

    // frame 3: centre (-2,2) clips to X 0..1, Y 0..5
    fg_cnt = 0;
    tick();
    base = cyc;
    chk("f3_sof", sof, 1'b1);
    chk("f3_fg_00", {r, g, b}, C_FG);
    while (cyc - base < FR - 1) begin
      tick();
      p = cyc - base;
      if (p == tp(1, 5))  chk("f3_fg_corner", {r, g, b}, C_FG);
      if (p == tp(2, 3))  chk("f3_bg_x2", {r, g, b}, C_BG);
      if (p == tp(0, 6))  chk("f3_bg_y6", {r, g, b}, C_BG);
      if (p == tp(39, 2)) chk("f3_no_wrap", {r, g, b}, C_BG);
    end
    chk("f3_fg_count", fg_cnt, 12);

    // frame 4: reset mid-frame at (45,15)
    tick();
    base = cyc;
    eof_cnt = 0;
    while (cyc - base < tp(45, 15)) tick();
    chk("mid_hs_before", hs, 1'b1);
    chk("mid_y_before", spot_y, 11'd15);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hs", hs, 1'b0);
    chk("mid_rst_blank", blank, 1'b1);
    chk("mid_rst_x", spot_x, 11'd0);
    chk("mid_rst_y", spot_y, 11'd0);
    chk("mid_rst_rgb", {r, g, b}, 24'h0);
    repeat (3) tick();
    chk("mid_rst_sof", sof, 1'b0);
    reset_n = 1'b1;
    tick();
    base = cyc;
    chk("restart_sof", sof, 1'b1);
    chk("restart_x", spot_x, 11'd0);
    chk("restart_y", spot_y, 11'd0);
    chk("aborted_no_eof", eof_cnt, 0);
    while (cyc - base < FR) tick();
    chk("restart_eof_ofs", last_eof - base, EOF_OFS);
    chk("restart_eof_cnt", eof_cnt, 1);
    chk("restart_next_sof", sof, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
